// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: transmit-side byte buffer and launcher for a UART transmitter.
// Bytes pushed by the host are queued in a synchronous FIFO. A small FSM
// hands them one at a time to the transmitter, so the host never polls busy.
//
// Handshakes:
//   Host side: a push is taken on any clock where wr_en is high and the FIFO
//   has room. "Room" includes the slot freed by a pop in the same cycle.
//   A push that cannot be taken is dropped and latches 'overflow'.
//   Transmitter side: tx_start is a registered one-cycle launch pulse with
//   tx_data stable from that cycle until the next launch. The transmitter
//   must raise tx_busy within 4 cycles of the launch, or the byte is treated
//   as lost. A later one-cycle tx_done ends the frame.
//
// Optional feature (macro UART_TX_FIFO_THRESH_EN): adds input 'thresh' and a
// registered low-watermark output 'low_wm' = (count <= thresh), used as a
// refill interrupt.
//
// dbg_state exposes the launcher FSM: 0 IDLE, 1 LAUNCH, 2 WAIT_BUSY,
// 3 WAIT_DONE.
module uart_tx_fifo #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16,
  localparam int PW       = $clog2(DEPTH),
  localparam int CW       = PW + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 full,
  output logic                 empty,
  output logic [CW-1:0]        count,
  output logic                 overflow,
  input  logic                 ovf_clr,
  output logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  input  logic                 tx_done,
`ifdef UART_TX_FIFO_THRESH_EN
  input  logic [CW-1:0]        thresh,
  output logic                 low_wm,
`endif
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [1:0]           wb_cnt;
  logic                 busy_timeout;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count_nxt;
  logic                 push, pop, reject;

  // Pop only in LAUNCH. A full FIFO still accepts a push in that cycle
  // because the head slot is freed at the same edge.
  assign pop    = enable && (state == S_LAUNCH);
  assign push   = enable && wr_en && (!full || pop);
  assign reject = enable && wr_en && !push;

  assign dbg_state = state;

  // Next occupancy; full/empty are registered from it so they track count exactly.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // FIFO storage write; stale entries are harmless since pointers gate reads.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and flags; disable flushes exactly like reset.
  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == CW'(DEPTH));
    end
  end

  // Sticky overflow: set by a dropped push or a launch the transmitter never
  // took. A set in the same cycle as ovf_clr wins. The flag survives disable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (enable) begin
      if (reject || busy_timeout) overflow <= 1'b1;
      else if (ovf_clr)           overflow <= 1'b0;
    end
  end

  // Launcher state register.
  always_ff @(posedge clk) begin
    if (!rst_n || !enable) state <= S_IDLE;
    else                   state <= state_nxt;
  end

  // Cycles spent in WAIT_BUSY, restarted on every entry.
  always_ff @(posedge clk) begin
    if (!rst_n || !enable || state != S_WAIT_BUSY) wb_cnt <= '0;
    else                                           wb_cnt <= wb_cnt + 2'd1;
  end

  // Launcher next-state logic; tx_done outside WAIT_DONE is ignored.
  always_comb begin
    state_nxt    = state;
    busy_timeout = 1'b0;
    case (state)
      S_IDLE:      if (!empty && !tx_busy) state_nxt = S_LAUNCH;
      S_LAUNCH:    state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = S_WAIT_DONE;
        end else if (wb_cnt == 2'd3) begin
          state_nxt    = S_IDLE;
          busy_timeout = 1'b1;
        end
      end
      S_WAIT_DONE: if (tx_done) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Registered launch pulse and data; tx_data holds until the next launch.
  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_start <= pop;
      if (pop) tx_data <= mem[rd_ptr];
    end
  end

`ifdef UART_TX_FIFO_THRESH_EN
  // Low watermark, registered one cycle behind count.
  always_ff @(posedge clk) begin
    if (!rst_n) low_wm <= 1'b1;
    else        low_wm <= (count <= thresh);
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo with a small transmitter
// model. The model answers each tx_start with busy for a programmable length
// followed by a one-cycle done. It checks every launched byte against exp_q.
module tb_uart_tx_fifo;

  localparam int DW = 8;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst_n, enable, wr_en, ovf_clr;
  logic [DW-1:0] wr_data;
  logic          full, empty, overflow, tx_start, tx_busy, tx_done;
  logic [CW-1:0] count;
  logic [DW-1:0] tx_data;
  logic [1:0]    dbg_state;
`ifdef UART_TX_FIFO_THRESH_EN
  logic [CW-1:0] thresh;
  logic          low_wm;
`endif

  // Transmitter model controls and state
  logic          stall, model_on;
  logic          m_busy, m_done, prev_start;
  int            m_cnt, m_len;
  int            n_start, n_done;

  logic [DW-1:0] exp_q[$];
  int            errors = 0;
  int            checks = 0;

  assign tx_busy = stall | m_busy;
  assign tx_done = m_done;

  uart_tx_fifo #(.DATA_BITS(DW), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .ovf_clr(ovf_clr), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .tx_done(tx_done),
`ifdef UART_TX_FIFO_THRESH_EN
    .thresh(thresh), .low_wm(low_wm),
`endif
    .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Transmitter model plus scoreboard of launched bytes.
  always @(negedge clk) begin
    prev_start <= tx_start;
    if (!rst_n || !enable) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
    end else begin
      m_done <= 1'b0;
      if (tx_start) begin
        check("start_one_cycle", {31'd0, prev_start}, 32'd0);
        if (model_on) begin
          n_start++;
          if (exp_q.size() == 0) check("start_unexpected", 32'd1, 32'd0);
          else                   check("tx_data", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
          m_busy <= 1'b1;
          m_cnt  <= m_len;
        end
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          n_done++;
        end
      end
    end
  end

  // Driver: one push per cycle, returns one negedge after the sampling edge.
  task automatic push(input logic [DW-1:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!(dbg_state == 2'd0 && empty && !m_busy && m_cnt == 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, n < 300}, 32'd1);
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw;
    int   n;
    rst_n = 1'b0; enable = 1'b1; wr_en = 1'b0; wr_data = '0; ovf_clr = 1'b0;
    stall = 1'b0; model_on = 1'b1; m_len = 3; n_start = 0; n_done = 0;
`ifdef UART_TX_FIFO_THRESH_EN
    thresh = '0;
`endif
    // Reset
    repeat (3) @(negedge clk);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
`ifdef UART_TX_FIFO_THRESH_EN
    check("rst_low_wm", 32'(low_wm), 32'd1);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Single byte latency: tx_start two cycles after wr_en sampled
    exp_q.push_back(8'hA5);
    push(8'hA5);
    check("lat_count", 32'(count), 32'd1);
    check("lat_start_c1", 32'(tx_start), 32'd0);
    @(negedge clk);
    check("lat_start_c2", 32'(tx_start), 32'd0);
    check("lat_state_launch", 32'(dbg_state), 32'd1);
    @(negedge clk);
    check("lat_start_c3", 32'(tx_start), 32'd1);
    check("lat_tx_data", 32'(tx_data), 32'hA5);
    check("lat_empty", 32'(empty), 32'd1);
    @(negedge clk);
    check("lat_start_drop", 32'(tx_start), 32'd0);
    check("lat_data_hold", 32'(tx_data), 32'hA5);
    wait_idle("lat_idle");

    // Fill with transmitter stalled, then overflow push
    stall = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(i));
      push(8'(i));
    end
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd16);
    check("fill_no_ovf", 32'(overflow), 32'd0);
    push(8'hEE);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd16);

    // Drain in order, one start per done
    n_start = 0; n_done = 0;
    stall = 1'b0;
    wait_idle("drain_idle");
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_q_left", 32'(exp_q.size()), 32'd0);
    check("drain_starts", 32'(n_start), 32'd16);
    check("drain_dones", 32'(n_done), 32'd16);

    // Overflow clear
    check("ovf_still_set", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Full FIFO accepts a push in the LAUNCH cycle
    stall = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(8'h10 + i));
      push(8'(8'h10 + i));
    end
    check("lp_full", 32'(full), 32'd1);
    stall = 1'b0;
    @(negedge clk);
    check("lp_state_launch", 32'(dbg_state), 32'd1);
    exp_q.push_back(8'h55);
    push(8'h55);
    check("lp_count", 32'(count), 32'd16);
    check("lp_full_kept", 32'(full), 32'd1);
    check("lp_no_ovf", 32'(overflow), 32'd0);
    wait_idle("lp_idle");
    check("lp_q_left", 32'(exp_q.size()), 32'd0);

    // Drop enable in WAIT_DONE with 5 queued
    m_len = 20;
    exp_q.push_back(8'h30);
    for (int i = 0; i < 6; i++) push(8'(8'h30 + i));
    check("en_state_wait_done", 32'(dbg_state), 32'd3);
    check("en_count_before", 32'(count), 32'd5);
    enable = 1'b0;
    @(negedge clk);
    check("en_count", 32'(count), 32'd0);
    check("en_empty", 32'(empty), 32'd1);
    check("en_state", 32'(dbg_state), 32'd0);
    check("en_tx_start", 32'(tx_start), 32'd0);
    check("en_tx_data", 32'(tx_data), 32'd0);
    @(negedge clk);
    m_len = 3;
    enable = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (tx_start) saw = 1'b1;
    end
    check("en_no_start", 32'(saw), 32'd0);
    check("en_q_left", 32'(exp_q.size()), 32'd0);

    // Busy never asserted: byte lost after 4 cycles in WAIT_BUSY
    model_on = 1'b0;
    push(8'h77);
    @(negedge clk);
    @(negedge clk);
    check("to_start", 32'(tx_start), 32'd1);
    repeat (3) @(negedge clk);
    check("to_still_waiting", 32'(dbg_state), 32'd2);
    check("to_ovf_before", 32'(overflow), 32'd0);
    @(negedge clk);
    check("to_state_idle", 32'(dbg_state), 32'd0);
    check("to_ovf_set", 32'(overflow), 32'd1);
    model_on = 1'b1;
    wait_idle("to_idle");

    // Clear, then rejected push with ovf_clr in the same cycle: set wins
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("sw_cleared", 32'(overflow), 32'd0);
    stall = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(8'h40 + i));
    ovf_clr = 1'b1;
    push(8'h99);
    ovf_clr = 1'b0;
    check("sw_ovf_wins", 32'(overflow), 32'd1);
    check("sw_count", 32'(count), 32'd16);
    enable = 1'b0;
    @(negedge clk);
    check("sw_flush_count", 32'(count), 32'd0);
    check("sw_flush_full", 32'(full), 32'd0);
    check("sw_ovf_held", 32'(overflow), 32'd1);
    enable = 1'b1;
    stall = 1'b0;
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("sw_ovf_clr", 32'(overflow), 32'd0);

`ifdef UART_TX_FIFO_THRESH_EN
    // Low watermark follows count one cycle late
    thresh = 5'd2;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'(8'h60 + i));
      push(8'(8'h60 + i));
    end
    @(negedge clk);
    check("wm_count3", 32'(count), 32'd3);
    check("wm_low_off", 32'(low_wm), 32'd0);
    stall = 1'b0;
    n = 0;
    while (count != 5'd2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wm_pop_seen", 32'(n < 20), 32'd1);
    check("wm_same_cycle", 32'(low_wm), 32'd0);
    @(negedge clk);
    check("wm_next_cycle", 32'(low_wm), 32'd1);
    wait_idle("wm_idle");
`endif

    check("final_q_left", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
